// File: rtl/ipm_shift_register_ctrl_v1_0_if.sv
// rtl/ipm_shift_register_ctrl_v1_0_if.sv - user datapath and distributed-RAM port bundle for the shift register controller
interface ipm_shift_register_ctrl_v1_0_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
  logic                  ce;
  logic                  flush;
  logic [ADDR_WIDTH-1:0] depth_sel;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_vld;
  logic                  ram_wr_en;
  logic [ADDR_WIDTH-1:0] ram_wr_addr;
  logic [DATA_WIDTH-1:0] ram_wr_data;
  logic [ADDR_WIDTH-1:0] ram_rd_addr;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  modport master (
    output ce, flush, depth_sel, din, ram_rd_data,
    input  dout, dout_vld, ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr
  );

  modport slave (
    input  ce, flush, depth_sel, din, ram_rd_data,
    output dout, dout_vld, ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr
  );
endinterface

// File: rtl/ipm_shift_register_ctrl_v1_0.sv
// rtl/ipm_shift_register_ctrl_v1_0.sv - circular-buffer sequencer for a variable-length delay line on distributed RAM
module ipm_shift_register_ctrl_v1_0 #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input logic clk,
    input logic rst_n,
    ipm_shift_register_ctrl_v1_0_if.slave bus
);
  typedef enum logic {S_FILL, S_RUN} state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_wp, w_wp_nxt;
  logic [ADDR_WIDTH-1:0] r_depth, w_depth_nxt;
  logic [ADDR_WIDTH:0]   r_fill, w_fill_nxt;
  logic [DATA_WIDTH-1:0] r_dout, w_dout_nxt;
  logic                  r_vld, w_vld_nxt;

  logic                  w_restart;
  logic [ADDR_WIDTH:0]   w_len;
  logic [ADDR_WIDTH:0]   w_fill_inc;

  // Any depth change invalidates the buffered history, same as flush.
  assign w_restart  = bus.flush | (bus.depth_sel != r_depth);
  assign w_len      = {1'b0, r_depth} + (ADDR_WIDTH + 1)'(1);
  assign w_fill_inc = r_fill + (ADDR_WIDTH + 1)'(1);

  assign bus.ram_wr_en   = bus.ce & ~w_restart;
  assign bus.ram_wr_addr = r_wp;
  assign bus.ram_wr_data = bus.din;
  // At full depth this equals r_wp; the async read returns the pre-write word.
  assign bus.ram_rd_addr = r_wp - r_depth - ADDR_WIDTH'(1);
  assign bus.dout        = r_dout;
  assign bus.dout_vld    = r_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FILL;
      r_wp    <= '0;
      r_depth <= '0;
      r_fill  <= '0;
      r_dout  <= '0;
      r_vld   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wp    <= w_wp_nxt;
      r_depth <= w_depth_nxt;
      r_fill  <= w_fill_nxt;
      r_dout  <= w_dout_nxt;
      r_vld   <= w_vld_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wp_nxt    = r_wp;
    w_depth_nxt = r_depth;
    w_fill_nxt  = r_fill;
    w_dout_nxt  = r_dout;
    w_vld_nxt   = r_vld;
    if (w_restart) begin
      w_depth_nxt = bus.depth_sel;
      w_fill_nxt  = '0;
      w_state_nxt = S_FILL;
      w_dout_nxt  = '0;
      w_vld_nxt   = 1'b0;
    end else if (bus.ce) begin
      w_wp_nxt = r_wp + ADDR_WIDTH'(1);
      case (r_state)
        S_FILL: begin
          w_fill_nxt = w_fill_inc;
          if (w_fill_inc == w_len) w_state_nxt = S_RUN;
        end
        S_RUN: begin
          w_dout_nxt = bus.ram_rd_data;
          w_vld_nxt  = 1'b1;
        end
        default: w_state_nxt = S_FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_ipm_shift_register_ctrl_v1_0.sv
// tb/tb_ipm_shift_register_ctrl_v1_0.sv - scoreboard bench with a sample-history reference model
module tb_ipm_shift_register_ctrl_v1_0;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int N  = 1 << AW;

  logic clk;
  logic rst_n;

  ipm_shift_register_ctrl_v1_0_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut_if ();

  ipm_shift_register_ctrl_v1_0 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (dut_if)
  );

  logic [DW-1:0] mem[N];
  assign dut_if.ram_rd_data = mem[dut_if.ram_rd_addr];
  always @(posedge clk) if (dut_if.ram_wr_en) mem[dut_if.ram_wr_addr] <= dut_if.ram_wr_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int dout;
    int vld;
    int wp;
    int rd;
    int wr_en;
    int wr_data;
  } rec_t;

  rec_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: the delay line as a list of accepted samples since restart.
  int   m_wp, m_dq, m_acc, m_dout, m_vld;
  int   hist[$];

  function automatic void model_reset();
    m_wp = 0; m_dq = 0; m_acc = 0; m_dout = 0; m_vld = 0;
    hist.delete();
  endfunction

  function automatic void model_edge(int c, int f, int d, int x);
    if (f != 0 || d != m_dq) begin
      m_dq = d; m_acc = 0; m_dout = 0; m_vld = 0;
      hist.delete();
    end else if (c != 0) begin
      m_wp = (m_wp + 1) % N;
      hist.push_back(x);
      if (hist.size() > N + 1) void'(hist.pop_front());
      m_acc++;
      if (m_acc > m_dq + 1) begin
        m_dout = hist[hist.size() - 1 - (m_dq + 1)];
        m_vld  = 1;
      end
    end
  endfunction

  task automatic check(string name, int act, int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Inputs change 2 time units after the rising edge; the expectation for
  // the state visible until the next rising edge is queued at the same time.
  task automatic step(int c, int f, int d, int x, int rn = 1);
    rec_t r;
    dut_if.ce        = c[0];
    dut_if.flush     = f[0];
    dut_if.depth_sel = d[AW-1:0];
    dut_if.din       = x[DW-1:0];
    rst_n            = rn[0];
    if (rn == 0) model_reset();
    r.dout    = m_dout;
    r.vld     = m_vld;
    r.wp      = m_wp;
    r.rd      = ((m_wp - m_dq - 1) % N + N) % N;
    r.wr_en   = (c != 0 && f == 0 && d == m_dq) ? 1 : 0;
    r.wr_data = x % 256;
    exp_q.push_back(r);
    @(posedge clk);
    if (rn != 0) model_edge(c, f, d, x % 256);
    #2;
  endtask

  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        check("dout", int'(dut_if.dout), r.dout);
        check("dout_vld", int'(dut_if.dout_vld), r.vld);
        check("ram_wr_addr", int'(dut_if.ram_wr_addr), r.wp);
        check("ram_rd_addr", int'(dut_if.ram_rd_addr), r.rd);
        check("ram_wr_en", int'(dut_if.ram_wr_en), r.wr_en);
        check("ram_wr_data", int'(dut_if.ram_wr_data), r.wr_data);
      end
    end
  end

  int pat[5] = '{1, 0, 1, 1, 0};

  initial begin
    for (int i = 0; i < N; i++) mem[i] = DW'($urandom);
    rst_n            = 1'b0;
    dut_if.ce        = 1'b0;
    dut_if.flush     = 1'b0;
    dut_if.depth_sel = '0;
    dut_if.din       = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;

    for (int i = 1; i <= 20; i++) step(1, 0, 3, i);
    for (int i = 1; i <= 50; i++) step(1, 0, 15, i);
    for (int i = 0; i < 15; i++) step(pat[i % 5], 0, 0, int'($urandom_range(0, 255)));
    for (int i = 1; i <= 10; i++) step(1, 0, 3, 100 + i);
    step(1, 1, 3, 77);
    for (int i = 1; i <= 7; i++) step(1, 0, 3, 120 + i);
    step(1, 0, 7, 200);
    for (int i = 1; i <= 12; i++) step(1, 0, 7, 200 + i);
    for (int i = 1; i <= 8; i++) step(1, 0, 3, 30 + i);
    step(1, 0, 3, 99, 0);
    step(1, 0, 3, 98, 0);
    for (int i = 1; i <= 12; i++) step(1, 0, 3, i);

    for (int i = 0; i < 600; i++) begin
      int c, f, d;
      c = ($urandom_range(0, 9) < 7) ? 1 : 0;
      f = ($urandom_range(0, 99) < 3) ? 1 : 0;
      d = int'(dut_if.depth_sel);
      if ($urandom_range(0, 99) < 3) d = int'($urandom_range(0, N - 1));
      if ($urandom_range(0, 199) == 0) step(c, f, d, int'($urandom_range(0, 255)), 0);
      else step(c, f, d, int'($urandom_range(0, 255)));
    end
    step(0, 0, int'(dut_if.depth_sel), 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
